dmem_block_mover: RTL and testbench
===================================

Name: dmem_block_mover

Overview:
- Bus initiator for the data memory. Drives address, write data and write enable; consumes registered read data.
- Executes block COPY (src→dst) and FILL (pattern→dst) commands issued by the control unit or the testbench.
- Used for memory initialisation, stack/frame moves and verification dumps without CPU involvement.
- Produces a running checksum of the words written, for self-checking.

Parameters:
- DSIZE, 16, data word width (matches data memory word).
- MEM_SPACE, 8, address width; memory holds 2**MEM_SPACE words.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  1  0 = COPY, 1 = FILL.
- src  input  MEM_SPACE  COPY source base address.
- dst  input  MEM_SPACE  destination base address.
- len  input  MEM_SPACE+1  word count, 0..2**MEM_SPACE.
- pattern  input  DSIZE  FILL data.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- checksum  output  DSIZE  sum of all words written by the last command, modulo 2**DSIZE.
- mem_addr  output  MEM_SPACE  memory address.
- mem_wdata  output  DSIZE  memory write data.
- mem_we  output  1  memory write enable, active-high.
- mem_rdata  input  DSIZE  memory read data; valid the cycle after its address was presented.

Behaviour:
- Reset (async): state = IDLE; all internal pointers, counter and checksum = 0. busy = 0, done = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - When start = 1: latch src_ptr = src, dst_ptr = dst, cnt = len, mode, pattern; clear checksum.
  - Next state: if len = 0 → DONE; else if COPY → RD; else (FILL) → WR.
- RD (COPY only): mem_addr = src_ptr, mem_we = 0. Next state is always WR.
- WR:
  - mem_addr = dst_ptr, mem_we = 1.
  - mem_wdata = mem_rdata (COPY) or the latched pattern (FILL).
  - At the clock edge: checksum += mem_wdata; src_ptr++ and dst_ptr++ (each modulo 2**MEM_SPACE); cnt--.
  - Next state: if cnt was 1 → DONE; else COPY → RD, FILL → WR.
- DONE: done = 1 for exactly one cycle, busy = 1, mem_we = 0. Next state IDLE.
- Throughput and latency:
  - COPY: 2 cycles per word (read address cycle, then write cycle that uses the registered mem_rdata).
  - FILL: 1 cycle per word.
  - Total cycles from the start edge to the done pulse: COPY 2·len + 1, FILL len + 1, len = 0 gives 1.
- Memory outputs are combinational from the state and pointer registers; no bubbles between words.
- start while busy = 1 is ignored; the command is not queued.
- Address wrap: pointers wrap from 2**MEM_SPACE-1 to 0, with no error indication.
- len = 2**MEM_SPACE is legal and covers the whole memory.
- Overlapping COPY is strictly word-by-word ascending. With dst > src and overlap, source words are overwritten before they are read, replicating the leading data. This is defined behaviour, not an error.
- Inputs src/dst/len/mode/pattern are don't-care except in the cycle start is accepted.
- rst asserted mid-command aborts immediately: mem_we drops to 0 asynchronously, there is no done pulse, and the checksum is cleared.
- checksum holds its value after DONE until the next accepted start.

Test Plan:
- FILL dst=8'h10, len=4, pattern=16'hA5A5 → mem[0x10..0x13]=A5A5; done exactly 5 cycles after start; checksum=16'h9694.
- Preload mem[0..2]=1,2,3; COPY src=0, dst=0x40, len=3 → mem[0x40..0x42]=1,2,3; done 7 cycles after start; checksum=6; mem_we high in alternate cycles only.
- COPY src=0xFE, dst=0x20, len=4 with mem[0xFE]=7, mem[0xFF]=8, mem[0]=9, mem[1]=10 → mem[0x20..0x23]=7,8,9,10 (source wrap).
- Overlap: mem[0]=5, mem[1]=6; COPY src=0, dst=1, len=2 → mem[1]=5, mem[2]=5.
- len=0 → done one cycle after start, mem_we never asserted, checksum=0; a second start pulsed while busy during a len=4 FILL is ignored (exactly 4 writes, one done pulse).
- Assert rst during the 3rd WR of a FILL with len=10 → mem_we=0 immediately; busy=0, done=0, checksum=0; a subsequent command runs normally.

Source files
------------

// File: rtl/dmem_block_mover_if.sv
// Command and data-memory bus bundle for the block mover.
// The master modport is the mover's view; slave is the controller/memory side.
interface dmem_block_mover_if #(
  parameter int DSIZE     = 16,
  parameter int MEM_SPACE = 8
);
  logic                 start;
  logic                 mode;
  logic [MEM_SPACE-1:0] src;
  logic [MEM_SPACE-1:0] dst;
  logic [MEM_SPACE:0]   len;
  logic [DSIZE-1:0]     pattern;
  logic                 busy;
  logic                 done;
  logic [DSIZE-1:0]     checksum;
  logic [MEM_SPACE-1:0] mem_addr;
  logic [DSIZE-1:0]     mem_wdata;
  logic                 mem_we;
  logic [DSIZE-1:0]     mem_rdata;

  modport master (
    input  start, mode, src, dst, len, pattern, mem_rdata,
    output busy, done, checksum, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output start, mode, src, dst, len, pattern, mem_rdata,
    input  busy, done, checksum, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_block_mover.sv
// Data-memory block mover: COPY (src->dst) or FILL (pattern->dst), word by
// word ascending, with a running modular checksum of every word written.
module dmem_block_mover #(
  parameter int DSIZE     = 16,
  parameter int MEM_SPACE = 8
) (
  input  logic                clk,
  input  logic                rst,
  dmem_block_mover_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t               state_q, state_d;
  logic [MEM_SPACE-1:0] src_q, src_d;
  logic [MEM_SPACE-1:0] dst_q, dst_d;
  logic [MEM_SPACE:0]   cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [DSIZE-1:0]     pat_q, pat_d;
  logic [DSIZE-1:0]     csum_q, csum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pat_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      csum_q  <= csum_d;
    end
  end

  // Memory outputs decode straight from registered state so words stream
  // back to back; COPY write data is the memory's registered read data.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    pat_d         = pat_q;
    csum_d        = csum_q;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d  = bus.src;
          dst_d  = bus.dst;
          cnt_d  = bus.len;
          mode_d = bus.mode;
          pat_d  = bus.pattern;
          csum_d = '0;
          if (bus.len == '0)  state_d = DONE;
          else if (bus.mode)  state_d = WR;
          else                state_d = RD;
        end
      end
      RD: begin
        bus.mem_addr = src_q;
        state_d      = WR;
      end
      WR: begin
        bus.mem_addr  = dst_q;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = mode_q ? pat_q : bus.mem_rdata;
        csum_d        = csum_q + bus.mem_wdata;
        src_d         = src_q + 1'b1;
        dst_d         = dst_q + 1'b1;
        cnt_d         = cnt_q - 1'b1;
        if (cnt_q == 1)   state_d = DONE;
        else if (mode_q)  state_d = WR;
        else              state_d = RD;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.checksum = csum_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Scoreboard bench for dmem_block_mover: expected writes and checksums are
// queued at command issue and consumed by a monitor watching the memory bus.
module tb_dmem_block_mover;
  localparam int DSIZE = 16;
  localparam int MS    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_block_mover_if #(.DSIZE(DSIZE), .MEM_SPACE(MS)) bus ();

  dmem_block_mover #(.DSIZE(DSIZE), .MEM_SPACE(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Synchronous-read memory model with a preload port.
  logic [DSIZE-1:0] mem [0:(1<<MS)-1];
  logic             pre_we = 1'b0;
  logic [MS-1:0]    pre_addr = '0;
  logic [DSIZE-1:0] pre_data = '0;
  logic [DSIZE-1:0] rdata_q;
  always @(posedge clk) begin
    if (pre_we)          mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  int checks   = 0;
  int failures = 0;
  logic [MS+DSIZE-1:0] wq[$];
  logic [DSIZE-1:0]    cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", {8'h0, bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
        else chk("write", {8'h0, bus.mem_addr, bus.mem_wdata}, {8'h0, wq.pop_front()});
      end
      if (bus.done) begin
        if (cq.size() == 0) chk("unexpected_done", {16'h0, bus.checksum}, 32'hFFFF_FFFF);
        else chk("checksum", {16'h0, bus.checksum}, {16'h0, cq.pop_front()});
      end
    end
  end

  task automatic preload(input logic [MS-1:0] a, input logic [DSIZE-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic exp_wr(input logic [MS-1:0] a, input logic [DSIZE-1:0] d);
    wq.push_back({a, d});
  endtask

  // Issue one command, wait for done, check latency; optionally pulse a
  // second start at cycle inj (0 = none) and check COPY write alternation.
  task automatic run_cmd(input string name, input logic m, input logic [MS-1:0] s,
                         input logic [MS-1:0] d, input logic [MS:0] l,
                         input logic [DSIZE-1:0] p, input int exp_cyc,
                         input int inj, input bit chk_alt);
    int  cyc;
    bit  prev_we, back2back;
    @(negedge clk);
    bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.pattern = p;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; prev_we = bus.mem_we; back2back = 1'b0;
    while (!bus.done && cyc < 600) begin
      if (inj != 0 && cyc == inj) begin
        bus.mode = 1'b1; bus.dst = 8'h70; bus.len = 9'd2; bus.pattern = 16'h0009;
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.mem_we && prev_we) back2back = 1'b1;
      prev_we = bus.mem_we;
    end
    chk({name, "_done_seen"}, {31'h0, bus.done}, 32'd1);
    chk({name, "_latency"}, cyc, exp_cyc);
    if (chk_alt) chk({name, "_we_alternate"}, {31'h0, back2back}, 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.pattern = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'h0, bus.busy}, 32'd0);
    chk("rst_done",  {31'h0, bus.done}, 32'd0);
    chk("rst_we",    {31'h0, bus.mem_we}, 32'd0);
    chk("rst_addr",  {24'h0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", {16'h0, bus.mem_wdata}, 32'd0);
    chk("rst_csum",  {16'h0, bus.checksum}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // FILL 4 x A5A5 at 0x10
    for (int i = 0; i < 4; i++) exp_wr(8'h10 + 8'(i), 16'hA5A5);
    cq.push_back(16'h9694);
    run_cmd("fill4", 1'b1, 8'h00, 8'h10, 9'd4, 16'hA5A5, 5, 0, 1'b0);
    chk("csum_hold", {16'h0, bus.checksum}, 32'h9694);

    // COPY 1,2,3 from 0 to 0x40
    preload(8'h00, 16'd1); preload(8'h01, 16'd2); preload(8'h02, 16'd3);
    exp_wr(8'h40, 16'd1); exp_wr(8'h41, 16'd2); exp_wr(8'h42, 16'd3);
    cq.push_back(16'd6);
    run_cmd("copy3", 1'b0, 8'h00, 8'h40, 9'd3, 16'h0, 7, 0, 1'b1);

    // COPY with source wrap
    preload(8'hFE, 16'd7); preload(8'hFF, 16'd8); preload(8'h00, 16'd9); preload(8'h01, 16'd10);
    exp_wr(8'h20, 16'd7); exp_wr(8'h21, 16'd8); exp_wr(8'h22, 16'd9); exp_wr(8'h23, 16'd10);
    cq.push_back(16'd34);
    run_cmd("copy_wrap", 1'b0, 8'hFE, 8'h20, 9'd4, 16'h0, 9, 0, 1'b1);

    // Overlapping COPY replicates the leading word
    preload(8'h00, 16'd5); preload(8'h01, 16'd6);
    exp_wr(8'h01, 16'd5); exp_wr(8'h02, 16'd5);
    cq.push_back(16'd10);
    run_cmd("copy_ovl", 1'b0, 8'h00, 8'h01, 9'd2, 16'h0, 5, 0, 1'b1);

    // len = 0
    cq.push_back(16'd0);
    run_cmd("len0", 1'b1, 8'h00, 8'h30, 9'd0, 16'hBEEF, 1, 0, 1'b0);

    // FILL with ignored start while busy
    for (int i = 0; i < 4; i++) exp_wr(8'h60 + 8'(i), 16'h0003);
    cq.push_back(16'd12);
    run_cmd("busy_ign", 1'b1, 8'h00, 8'h60, 9'd4, 16'h0003, 5, 2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("busy_ign_idle", {31'h0, bus.busy}, 32'd0);

    // Reset during the 3rd write of a 10-word FILL
    exp_wr(8'h80, 16'h1111); exp_wr(8'h81, 16'h1111);
    @(negedge clk);
    bus.mode = 1'b1; bus.dst = 8'h80; bus.len = 9'd10; bus.pattern = 16'h1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_we", {31'h0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we",   {31'h0, bus.mem_we}, 32'd0);
    chk("abort_busy", {31'h0, bus.busy}, 32'd0);
    chk("abort_done", {31'h0, bus.done}, 32'd0);
    chk("abort_csum", {16'h0, bus.checksum}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Normal command after the abort
    exp_wr(8'h90, 16'h0100); exp_wr(8'h91, 16'h0100);
    cq.push_back(16'h0200);
    run_cmd("post_rst", 1'b1, 8'h00, 8'h90, 9'd2, 16'h0100, 3, 0, 1'b0);

    cyc = wq.size();
    chk("writes_pending", cyc, 0);
    cyc = cq.size();
    chk("dones_pending", cyc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
